// File: rtl/frame_sram_pkg.sv
// frame_sram_pkg: shared widths, arbiter state encoding and default timing
// for the frame-buffer SRAM arbiter and its read tracker.
package frame_sram_pkg;

  localparam int ADDR_W           = 20;
  localparam int DATA_W           = 18;
  localparam int DEF_SLOT_CYCLES  = 4;
  localparam int DEF_READ_LATENCY = 12;

  // Kind of access issued in the current SRAM slot
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    TURN  = 2'd3
  } state_t;

endpackage

// File: rtl/sram_read_tracker.sv
// sram_read_tracker: carries one marker per issued read through a
// READ_LATENCY-deep shift register and captures mem_rdata as each marker
// leaves. Markers never collapse, so several reads may be in flight.
module sram_read_tracker
  import frame_sram_pkg::*;
#(
  parameter int READ_LATENCY = DEF_READ_LATENCY
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rd_issue,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data
);

  logic [READ_LATENCY-1:0] vld_pipe;
  logic                    exiting;

  // Data is captured on the same edge the marker reaches the last stage
  generate
    if (READ_LATENCY == 1) begin : g_lat1
      assign exiting = rd_issue;
    end else begin : g_latn
      assign exiting = vld_pipe[READ_LATENCY-2];
    end
  endgenerate

  // Marker shift register and read-data capture; reset drops all markers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      rd_data  <= '0;
    end else begin
      vld_pipe[0] <= rd_issue;
      for (int i = 1; i < READ_LATENCY; i++) vld_pipe[i] <= vld_pipe[i-1];
      if (exiting) rd_data <= mem_rdata;
    end
  end

  assign rd_valid = vld_pipe[READ_LATENCY-1];

endmodule

// File: rtl/frame_sram_arbiter.sv
// frame_sram_arbiter: merges the capture write stream and the display read
// stream into one SRAM access per slot. Reads win; a write->read switch
// inserts one dead TURN slot. Optional starvation guard is enabled with
// the SRAM_ARB_STARVE_GUARD_EN macro.
module frame_sram_arbiter
  import frame_sram_pkg::*;
#(
  parameter int SLOT_CYCLES    = DEF_SLOT_CYCLES,
  parameter int READ_LATENCY   = DEF_READ_LATENCY,
  parameter int MAX_READ_BURST = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ack,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_ack,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int SW = $clog2(SLOT_CYCLES);

  generate
    if (SLOT_CYCLES < 2 || READ_LATENCY < 1 || MAX_READ_BURST < 1) begin : g_bad_cfg
      $error("frame_sram_arbiter: illegal parameter combination");
    end
  endgenerate

  logic [SW-1:0] slot_cnt;
  state_t        state, next_st;
  logic          issue;
  logic          starve;

  // Issue cycle is slot 0; gated with rst_n so acks stay low during reset
  assign issue = rst_n && (slot_cnt == '0);

`ifdef SRAM_ARB_STARVE_GUARD_EN
  localparam int BW = ($clog2(MAX_READ_BURST + 1) > 4) ? $clog2(MAX_READ_BURST + 1) : 4;
  logic [BW-1:0] burst_cnt;

  assign starve = wr_req && (burst_cnt >= BW'(MAX_READ_BURST));

  // Count consecutive read slots taken while a write is waiting
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                           burst_cnt <= '0;
    else if (!wr_req)                     burst_cnt <= '0;
    else if (issue && next_st == WRITE)   burst_cnt <= '0;
    else if (issue && next_st == READ)    burst_cnt <= burst_cnt + BW'(1);
  end
`else
  assign starve = 1'b0;
`endif

  // Slot decision: guard override, then reads (with turnaround), then writes
  always_comb begin
    next_st = IDLE;
    if (starve)      next_st = WRITE;
    else if (rd_req) next_st = (state == WRITE) ? TURN : READ;
    else if (wr_req) next_st = WRITE;
  end

  assign rd_ack = issue && (next_st == READ);
  assign wr_ack = issue && (next_st == WRITE);

  // Free-running slot counter, wrapping at SLOT_CYCLES
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                 slot_cnt <= '0;
    else if (slot_cnt == SW'(SLOT_CYCLES - 1))  slot_cnt <= '0;
    else                                        slot_cnt <= slot_cnt + SW'(1);
  end

  // Slot FSM; SRAM drive registers change only at the issue edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_we    <= 1'b0;
    end else if (issue) begin
      state <= next_st;
      case (next_st)
        READ: begin
          mem_addr <= rd_addr;
          mem_we   <= 1'b0;
        end
        WRITE: begin
          mem_addr  <= wr_addr;
          mem_wdata <= wr_data;
          mem_we    <= 1'b1;
        end
        default: mem_we <= 1'b0;
      endcase
    end
  end

  sram_read_tracker #(
    .READ_LATENCY(READ_LATENCY)
  ) u_rd_trk (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_issue (rd_ack),
    .mem_rdata(mem_rdata),
    .rd_valid (rd_valid),
    .rd_data  (rd_data)
  );

endmodule

// File: tb/tb_frame_sram_arbiter.sv
// tb_frame_sram_arbiter: table-driven slot vectors plus hand sequences for
// read latency/ordering, reset with reads in flight and write starvation.
module tb_frame_sram_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_req, rd_req;
  logic [19:0] wr_addr, rd_addr;
  logic [17:0] wr_data;
  logic        wr_ack, rd_ack, rd_valid, mem_we;
  logic [17:0] rd_data, mem_wdata, mem_rdata;
  logic [19:0] mem_addr;

  int checks = 0;
  int failures = 0;

  frame_sram_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack),
    .rd_valid(rd_valid), .rd_data(rd_data),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // SRAM model: writes land on any clock with mem_we high; read data for an
  // address presented at the issue edge appears in the cycle before the
  // arbiter's capture edge (issue edge + 11 clocks).
  logic [17:0] mem [0:1023];
  logic [19:0] addr_d [0:9];
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr[9:0]] <= mem_wdata;
    addr_d[0] <= mem_addr;
    for (int k = 1; k < 10; k++) addr_d[k] <= addr_d[k-1];
  end
  assign mem_rdata = mem[addr_d[9][9:0]];

  // Monitor: timestamps acks and returns, sampled mid-cycle
  int cyc = 0;
  int ack_q[$];
  int vt_q[$];
  logic [17:0] vd_q[$];
  always begin
    @(negedge clk);
    #2;
    if (rst_n) begin
      cyc++;
      if (rd_ack) ack_q.push_back(cyc);
      if (rd_valid) begin
        vt_q.push_back(cyc);
        vd_q.push_back(rd_data);
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  typedef struct packed {
    logic        rd;
    logic        wr;
    logic [19:0] ra;
    logic [19:0] wa;
    logic [17:0] wd;
    logic        e_rack;
    logic        e_wack;
    logic        e_we;
    logic [19:0] e_addr;
    logic [17:0] e_wdata;
  } vec_t;

  // Caller is at the negedge of an issue cycle; returns at the next one
  task automatic do_slot(input vec_t v, input int idx);
    rd_req = v.rd; wr_req = v.wr; rd_addr = v.ra; wr_addr = v.wa; wr_data = v.wd;
    #1;
    chk($sformatf("v%0d_rd_ack", idx), rd_ack, v.e_rack);
    chk($sformatf("v%0d_wr_ack", idx), wr_ack, v.e_wack);
    @(negedge clk); #1;
    chk($sformatf("v%0d_mem", idx), {mem_we, mem_addr, mem_wdata}, {v.e_we, v.e_addr, v.e_wdata});
    chk($sformatf("v%0d_ack_off_slot", idx), {rd_ack, wr_ack}, 2'b00);
    rd_req = 1'b0; wr_req = 1'b0;
    @(negedge clk); @(negedge clk); #1;
    chk($sformatf("v%0d_mem_hold", idx), {mem_we, mem_addr, mem_wdata}, {v.e_we, v.e_addr, v.e_wdata});
    @(negedge clk);
  endtask

  vec_t tbl [12];
  logic [17:0] exp_rd [6];
  int n_r, n_w;
  logic er, ew;

  initial begin
    //           rd   wr   ra        wa        wd        rack wack we   addr      wdata
    tbl[0]  = '{1'b0,1'b1,20'h00000,20'h00010,18'h2AAAA,1'b0,1'b1,1'b1,20'h00010,18'h2AAAA};
    tbl[1]  = '{1'b1,1'b0,20'h00010,20'h00000,18'h00000,1'b0,1'b0,1'b0,20'h00010,18'h2AAAA};
    tbl[2]  = '{1'b1,1'b0,20'h00010,20'h00000,18'h00000,1'b1,1'b0,1'b0,20'h00010,18'h2AAAA};
    tbl[3]  = '{1'b0,1'b0,20'h00000,20'h00000,18'h00000,1'b0,1'b0,1'b0,20'h00010,18'h2AAAA};
    tbl[4]  = '{1'b0,1'b1,20'h00000,20'h00100,18'h11111,1'b0,1'b1,1'b1,20'h00100,18'h11111};
    tbl[5]  = '{1'b0,1'b1,20'h00000,20'h00101,18'h22222,1'b0,1'b1,1'b1,20'h00101,18'h22222};
    tbl[6]  = '{1'b0,1'b1,20'h00000,20'h00102,18'h33333,1'b0,1'b1,1'b1,20'h00102,18'h33333};
    tbl[7]  = '{1'b0,1'b1,20'h00000,20'h00103,18'h04444,1'b0,1'b1,1'b1,20'h00103,18'h04444};
    tbl[8]  = '{1'b1,1'b1,20'h00100,20'h00200,18'h00155,1'b0,1'b0,1'b0,20'h00103,18'h04444};
    tbl[9]  = '{1'b1,1'b1,20'h00100,20'h00200,18'h00155,1'b1,1'b0,1'b0,20'h00100,18'h04444};
    tbl[10] = '{1'b0,1'b1,20'h00000,20'h00300,18'h3FFFF,1'b0,1'b1,1'b1,20'h00300,18'h3FFFF};
    tbl[11] = '{1'b0,1'b0,20'h00000,20'h00000,18'h00000,1'b0,1'b0,1'b0,20'h00300,18'h3FFFF};
    exp_rd = '{18'h2AAAA, 18'h11111, 18'h11111, 18'h22222, 18'h33333, 18'h04444};
    for (int k = 0; k < 1024; k++) mem[k] = '0;

    // Reset: requests asserted must not produce acks or drive the SRAM
    rst_n = 1'b0; wr_req = 1'b1; rd_req = 1'b1;
    rd_addr = 20'h12345; wr_addr = 20'h54321; wr_data = 18'h1;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_outputs", {wr_ack, rd_ack, rd_valid, mem_we, mem_addr, mem_wdata, rd_data}, '0);
    wr_req = 1'b0; rd_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) do_slot(tbl[i], i);

    // Back-to-back reads with rd_req held; address advances after each ack
    for (int i = 0; i < 4; i++) begin
      rd_req = 1'b1; rd_addr = 20'h00100 + 20'(i);
      #1;
      chk($sformatf("b2b%0d_rd_ack", i), rd_ack, 1'b1);
      repeat (4) @(negedge clk);
    end
    rd_req = 1'b0;
    repeat (16) @(negedge clk);

    // Every read returns exactly 12 cycles after its ack, in issue order
    chk("ret_ack_count", ack_q.size(), 6);
    chk("ret_valid_count", vt_q.size(), 6);
    for (int i = 0; i < 6 && i < ack_q.size() && i < vt_q.size(); i++) begin
      chk($sformatf("ret%0d_latency", i), vt_q[i] - ack_q[i], 12);
      chk($sformatf("ret%0d_data", i), vd_q[i], exp_rd[i]);
    end

    // Reset for one cycle with three reads in flight
    ack_q.delete(); vt_q.delete(); vd_q.delete();
    for (int i = 0; i < 3; i++) begin
      rd_req = 1'b1; rd_addr = 20'h00100 + 20'(i);
      if (i < 2) repeat (4) @(negedge clk);
    end
    @(negedge clk);
    rd_req = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_inflight_outputs", {wr_ack, rd_ack, rd_valid, mem_we, mem_addr, mem_wdata, rd_data}, '0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("rst_inflight_acks", ack_q.size(), 3);
    chk("rst_inflight_no_valid", vt_q.size(), 0);
    #1;
    chk("rst_after_outputs", {rd_valid, mem_we, mem_addr, mem_wdata, rd_data}, '0);

    // Both requests held continuously for 20 slots
    n_r = 0; n_w = 0;
    rd_req = 1'b1; wr_req = 1'b1; rd_addr = 20'h00010; wr_addr = 20'h00020; wr_data = 18'h0ABCD;
    for (int s = 0; s < 20; s++) begin
      #1;
`ifdef SRAM_ARB_STARVE_GUARD_EN
      er = (s % 10) < 8;
      ew = (s % 10) == 8;
`else
      er = 1'b1;
      ew = 1'b0;
`endif
      chk($sformatf("starve_slot%0d_acks", s), {rd_ack, wr_ack}, {er, ew});
      if (rd_ack) n_r++;
      if (wr_ack) n_w++;
      repeat (4) @(negedge clk);
    end
    rd_req = 1'b0; wr_req = 1'b0;
`ifdef SRAM_ARB_STARVE_GUARD_EN
    chk("starve_total", {n_r[15:0], n_w[15:0]}, {16'd16, 16'd2});
`else
    chk("starve_total", {n_r[15:0], n_w[15:0]}, {16'd20, 16'd0});
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/frame_sram_arbiter.md
# frame_sram_arbiter

- Two-port arbiter directly upstream of the SRAM interface in the frame-buffer path.
- Merges the capture-side write stream and the display-side read stream into one request per SRAM slot, and drives the interface's address, write-data and write-enable inputs.
- Tracks outstanding reads through a fixed-latency pipeline and returns tagged read data to the display prefetcher.
- Reads have priority because the display cannot stall; a starvation guard keeps captured pixels flowing.

## Interface
Parameters:
- SLOT_CYCLES, 4: clk cycles per SRAM slot (the interface runs the SRAM at clk/4). Must be ≥2.
- READ_LATENCY, 12: clk cycles from read issue to valid data on mem_rdata. Must be ≥1.
- MAX_READ_BURST, 8: consecutive read slots allowed while a write is pending (used only with the guard).

Ports:
- clk  in  1  system clock; single clock domain.
- rst_n  in  1  asynchronous, active-low reset.
- wr_req  in  1  capture write request; held until wr_ack.
- wr_addr  in  20  write word address.
- wr_data  in  18  write pixel word.
- wr_ack  out  1  one-cycle pulse: write issued this slot.
- rd_req  in  1  display read request; held until rd_ack.
- rd_addr  in  20  read word address.
- rd_ack  out  1  one-cycle pulse: read issued this slot.
- rd_valid  out  1  one-cycle pulse: rd_data valid.
- rd_data  out  18  returned read word.
- mem_addr  out  20  to interface addr.
- mem_wdata  out  18  to interface data_in.
- mem_we  out  1  to interface write_enable; active-high.
- mem_rdata  in  18  from interface data_out.

## Operation
Slot counter:
- slot_cnt counts 0..SLOT_CYCLES-1 and wraps.
- Arbitration happens only at slot_cnt==0, the issue cycle.

FSM states: IDLE, READ, WRITE, TURN. At each issue cycle:
- rd_req, and state≠WRITE or TURN was just taken → READ: mem_addr←rd_addr, mem_we←0, rd_ack=1.
- rd_req and last slot was WRITE → TURN: one dead slot, mem_we←0, no ack. The read issues in the next slot.
- wr_req only → WRITE: mem_addr←wr_addr, mem_wdata←wr_data, mem_we←1, wr_ack=1.
- neither → IDLE: mem_we←0; mem_addr and mem_wdata hold their last values.
- WRITE→WRITE needs no turnaround.

Outputs and request rules:
- mem_* are registered and held constant for the whole slot.
- Acks are combinational from the issue-cycle decision, so they are high only while slot_cnt==0.
- A requester may change its address or data only after the cycle its ack is seen.
- Dropping a request before ack is legal; nothing is issued.

Read return:
- A READ_LATENCY-bit shift register carries issue markers.
- When a marker exits, rd_valid=1 and rd_data captures mem_rdata in that cycle.
- Returns come back in issue order; no backpressure exists on rd_valid.

Reset:
- Reset clears every slot in flight; markers are discarded and no rd_valid follows.

## Timing
Reset values:
- wr_ack, rd_ack, rd_valid, mem_we = 0.
- mem_addr, mem_wdata, rd_data = 0.
- slot_cnt = 0; state = IDLE.
- The first issue cycle is the first clk edge after rst_n deasserts.

Latencies:
- Request to ack: 0–SLOT_CYCLES-1 cycles (waits for slot boundary), plus arbitration loss.
- mem_* update on the clk edge ending the ack cycle.
- rd_valid rises exactly READ_LATENCY cycles after the rd_ack edge.
- Peak throughput: one access per SLOT_CYCLES; write→read switch costs one extra slot.

Simultaneous and boundary cases:
- wr_req and rd_req on the same issue cycle → read wins, unless the guard overrides.
- Back-to-back reads can leave READ_LATENCY/SLOT_CYCLES markers in flight at once; the shift register must not collapse them.

## Configuration
- SRAM_ARB_STARVE_GUARD_EN defined:
  - A 4-bit-or-wider counter counts consecutive READ slots while wr_req is high.
  - When it reaches MAX_READ_BURST, the next issue cycle grants WRITE even if rd_req is high, then the counter clears.
  - The counter also clears on any WRITE slot or whenever wr_req is low.
- Undefined: strict read priority; writes can starve indefinitely; counter logic is absent.

## Structure
- Shared package frame_sram_pkg holds:
  - address width 20 and data width 18;
  - the state enum (IDLE, READ, WRITE, TURN);
  - default SLOT_CYCLES and READ_LATENCY.
- One sub-module, sram_read_tracker, holds the marker shift register and the rd_data capture.

## Test plan
- Reset release, write at 0x00010 with 0x2AAAA → wr_ack in the first issue cycle; mem_we=1, mem_addr=0x00010, mem_wdata=0x2AAAA for 4 cycles.
- Read 0x00010 after that write → one TURN slot, then rd_ack; rd_valid exactly 12 cycles after rd_ack, with rd_data equal to the modelled mem_rdata (0x2AAAA).
- wr_req and rd_req held together, guard undefined → 20 consecutive rd_acks and zero wr_acks.
- Same stimulus with SRAM_ARB_STARVE_GUARD_EN → 8 rd_acks, 1 wr_ack, then 1 TURN slot, repeating.
- Four reads back-to-back (0x00100–0x00103) → four rd_valid pulses 4 cycles apart, data in issue order.
- rst_n low for 1 cycle while 3 reads are in flight → no rd_valid afterward; all outputs at reset values.
